nn_data_path: RTL and testbench

// - Top-level training datapath for a small fixed-point neural-network engine.
// - Holds weight, input, label and microcode storage; runs a 12-bit microprogram.
// - Executes forward MAC/activation, error and gradient steps.
// - Streams 3-lane dC/dW vectors to the host; the host feeds updates back through the weight-update port.

---
 rtl/nn_data_path.sv | 258 +++++++++++++++++++++++++
 tb/tb_nn_data_path.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_data_path.sv
// nn_data_path: fixed-point NN training datapath with weight/input/label/code
// storage, a 12-bit microprogram sequencer and a registered dC/dW stream.
module nn_data_path #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned LANES      = 3,
  parameter int unsigned LAYERS     = 4,
  parameter int unsigned ROWS       = 4,
  parameter int unsigned CODE_DEPTH = 32
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [47:0] weight_storage_write_interface_write_data,
  input  logic [31:0] weight_storage_write_interface_write_layer_index,
  input  logic [31:0] weight_storage_write_interface_write_row_index,
  input  logic        weight_storage_is_write_interface_is_write,
  input  logic [47:0] weight_storage_update_weight_interface_dc_dw,
  input  logic [31:0] weight_storage_update_weight_interface_layer_index,
  input  logic [31:0] weight_storage_update_weight_interface_row_index,
  input  logic        weight_storage_is_update_interface_is_update,
  input  logic [47:0] input_storage_write_interface_write_data,
  input  logic [31:0] input_storage_write_interface_write_layer_index,
  input  logic [31:0] input_storage_write_interface_write_row_index,
  input  logic        input_storage_is_write_interface_is_write,
  input  logic [47:0] label_storage_write_interface_write_data,
  input  logic [31:0] label_storage_write_interface_write_layer_index,
  input  logic [31:0] label_storage_write_interface_write_row_index,
  input  logic        label_storage_is_write_interface_is_write,
  input  logic [11:0] code_storage_write_interface_write_data,
  input  logic [31:0] code_storage_write_interface_write_line,
  input  logic        code_storage_write_interface_is_write,
  input  logic        code_storage_enable_interface_enable,
  input  logic        controller_enable_interface_enable,
  input  logic        matrix_storage_locator_reset_interface_reset,
  output logic [47:0] backpropagator_0_dc_dw_stream_interface_dc_dw_stream,
  output logic        controller_use_z_interface_use_z
);

  localparam int unsigned ROW_W  = LANES * DATA_W;
  localparam int unsigned MAT_N  = LAYERS * ROWS;
  localparam int unsigned IDX_W  = $clog2(MAT_N);
  localparam int unsigned PC_W   = $clog2(CODE_DEPTH);
  localparam int unsigned INSN_W = 12;
  localparam int unsigned FRAC_W = 8;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDX  = 4'h1,
    OP_MAC  = 4'h2,
    OP_ACT  = 4'h3,
    OP_ERR  = 4'h4,
    OP_GRAD = 4'h5,
    OP_CLRZ = 4'h6,
    OP_SETZ = 4'h7,
    OP_HALT = 4'hF
  } opcode_e;

  // Q8.8 product, arithmetic-shifted back to Q8.8 and truncated
  function automatic logic [DATA_W-1:0] mul_q(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    logic signed [2*DATA_W-1:0] p;
    p = $signed(a) * $signed(b);
    return DATA_W'(p >>> FRAC_W);
  endfunction

  function automatic logic [ROW_W-1:0] row_mac(input logic [ROW_W-1:0] z,
                                               input logic [ROW_W-1:0] x,
                                               input logic [ROW_W-1:0] w);
    logic [ROW_W-1:0] r;
    for (int i = 0; i < int'(LANES); i++)
      r[i*DATA_W +: DATA_W] = z[i*DATA_W +: DATA_W] +
                              mul_q(x[i*DATA_W +: DATA_W], w[i*DATA_W +: DATA_W]);
    return r;
  endfunction

  function automatic logic [ROW_W-1:0] row_mul(input logic [ROW_W-1:0] a,
                                               input logic [ROW_W-1:0] b);
    logic [ROW_W-1:0] r;
    for (int i = 0; i < int'(LANES); i++)
      r[i*DATA_W +: DATA_W] = mul_q(a[i*DATA_W +: DATA_W], b[i*DATA_W +: DATA_W]);
    return r;
  endfunction

  function automatic logic [ROW_W-1:0] row_sub(input logic [ROW_W-1:0] a,
                                               input logic [ROW_W-1:0] b);
    logic [ROW_W-1:0] r;
    for (int i = 0; i < int'(LANES); i++)
      r[i*DATA_W +: DATA_W] = a[i*DATA_W +: DATA_W] - b[i*DATA_W +: DATA_W];
    return r;
  endfunction

  function automatic logic [ROW_W-1:0] row_relu(input logic [ROW_W-1:0] a);
    logic [ROW_W-1:0] r;
    for (int i = 0; i < int'(LANES); i++)
      r[i*DATA_W +: DATA_W] = a[(i+1)*DATA_W-1] ? '0 : a[i*DATA_W +: DATA_W];
    return r;
  endfunction

  function automatic logic in_range(input logic [31:0] layer, input logic [31:0] row);
    return (layer < LAYERS) && (row < ROWS);
  endfunction

  function automatic logic [IDX_W-1:0] mat_idx(input logic [31:0] layer,
                                               input logic [31:0] row);
    return IDX_W'(layer * ROWS + row);
  endfunction

  logic [ROW_W-1:0]  w_mem_q [MAT_N];
  logic [ROW_W-1:0]  w_mem_d [MAT_N];
  logic [ROW_W-1:0]  i_mem_q [MAT_N];
  logic [ROW_W-1:0]  i_mem_d [MAT_N];
  logic [ROW_W-1:0]  l_mem_q [MAT_N];
  logic [ROW_W-1:0]  l_mem_d [MAT_N];
  logic [INSN_W-1:0] code_q  [CODE_DEPTH];
  logic [INSN_W-1:0] code_d  [CODE_DEPTH];

  logic [PC_W-1:0]   pc_q, pc_d;
  logic [ROW_W-1:0]  x_q, x_d, z_q, z_d, a_q, a_d, e_q, e_d;
  logic [ROW_W-1:0]  dc_dw_q, dc_dw_d;
  logic              use_z_q, use_z_d;
  logic              halted_q, halted_d;

  logic [INSN_W-1:0] insn_c;
  opcode_e           opcode_c;
  logic [31:0]       op_layer_c, op_row_c;
  logic              op_valid_c;
  logic [IDX_W-1:0]  op_idx_c;
  logic [ROW_W-1:0]  w_rd_c, i_rd_c, l_rd_c;
  logic              exec_c;

  // Storage next-state: weight update first, then a same-row write overrides it
  always_comb begin
    w_mem_d = w_mem_q;
    i_mem_d = i_mem_q;
    l_mem_d = l_mem_q;
    code_d  = code_q;
    if (weight_storage_is_update_interface_is_update &&
        in_range(weight_storage_update_weight_interface_layer_index,
                 weight_storage_update_weight_interface_row_index)) begin
      w_mem_d[mat_idx(weight_storage_update_weight_interface_layer_index,
                      weight_storage_update_weight_interface_row_index)] =
        row_sub(w_mem_q[mat_idx(weight_storage_update_weight_interface_layer_index,
                                weight_storage_update_weight_interface_row_index)],
                weight_storage_update_weight_interface_dc_dw);
    end
    if (weight_storage_is_write_interface_is_write &&
        in_range(weight_storage_write_interface_write_layer_index,
                 weight_storage_write_interface_write_row_index)) begin
      w_mem_d[mat_idx(weight_storage_write_interface_write_layer_index,
                      weight_storage_write_interface_write_row_index)] =
        weight_storage_write_interface_write_data;
    end
    if (input_storage_is_write_interface_is_write &&
        in_range(input_storage_write_interface_write_layer_index,
                 input_storage_write_interface_write_row_index)) begin
      i_mem_d[mat_idx(input_storage_write_interface_write_layer_index,
                      input_storage_write_interface_write_row_index)] =
        input_storage_write_interface_write_data;
    end
    if (label_storage_is_write_interface_is_write &&
        in_range(label_storage_write_interface_write_layer_index,
                 label_storage_write_interface_write_row_index)) begin
      l_mem_d[mat_idx(label_storage_write_interface_write_layer_index,
                      label_storage_write_interface_write_row_index)] =
        label_storage_write_interface_write_data;
    end
    if (code_storage_write_interface_is_write &&
        (code_storage_write_interface_write_line < CODE_DEPTH)) begin
      code_d[PC_W'(code_storage_write_interface_write_line)] =
        code_storage_write_interface_write_data;
    end
  end

  // Storage arrays are never cleared by reset
  always_ff @(posedge clk_clk) begin
    w_mem_q <= w_mem_d;
    i_mem_q <= i_mem_d;
    l_mem_q <= l_mem_d;
    code_q  <= code_d;
  end

  // Instruction fetch, decode and operand read
  always_comb begin
    insn_c     = code_q[pc_q];
    opcode_c   = opcode_e'(insn_c[11:8]);
    op_layer_c = 32'(insn_c[7:4]);
    op_row_c   = 32'(insn_c[3:0]);
    op_valid_c = in_range(op_layer_c, op_row_c);
    op_idx_c   = mat_idx(op_layer_c, op_row_c);
    w_rd_c     = op_valid_c ? w_mem_q[op_idx_c] : '0;
    i_rd_c     = op_valid_c ? i_mem_q[op_idx_c] : '0;
    l_rd_c     = op_valid_c ? l_mem_q[op_idx_c] : '0;
    exec_c     = code_storage_enable_interface_enable &&
                 controller_enable_interface_enable && !halted_q;
  end

  // Execution next-state; locator reset has priority over execution
  always_comb begin
    pc_d     = pc_q;
    x_d      = x_q;
    z_d      = z_q;
    a_d      = a_q;
    e_d      = e_q;
    dc_dw_d  = dc_dw_q;
    use_z_d  = use_z_q;
    halted_d = halted_q;
    if (matrix_storage_locator_reset_interface_reset) begin
      pc_d     = '0;
      x_d      = '0;
      z_d      = '0;
      a_d      = '0;
      e_d      = '0;
      halted_d = 1'b0;
    end else if (exec_c) begin
      pc_d = (pc_q == PC_W'(CODE_DEPTH - 1)) ? '0 : pc_q + PC_W'(1);
      case (opcode_c)
        OP_LDX:  x_d = i_rd_c;
        OP_MAC:  z_d = row_mac(z_q, x_q, w_rd_c);
        OP_ACT:  a_d = row_relu(z_q);
        OP_ERR:  e_d = row_sub(use_z_q ? z_q : a_q, l_rd_c);
        OP_GRAD: dc_dw_d = row_mul(e_q, x_q);
        OP_CLRZ: z_d = '0;
        OP_SETZ: use_z_d = insn_c[0];
        OP_HALT: begin
          halted_d = 1'b1;
          pc_d     = pc_q;
        end
        default: ;
      endcase
    end
  end

  // Execution registers with synchronous active-high reset
  always_ff @(posedge clk_clk) begin
    if (reset_reset_n) begin
      pc_q     <= '0;
      x_q      <= '0;
      z_q      <= '0;
      a_q      <= '0;
      e_q      <= '0;
      dc_dw_q  <= '0;
      use_z_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      x_q      <= x_d;
      z_q      <= z_d;
      a_q      <= a_d;
      e_q      <= e_d;
      dc_dw_q  <= dc_dw_d;
      use_z_q  <= use_z_d;
      halted_q <= halted_d;
    end
  end

  assign backpropagator_0_dc_dw_stream_interface_dc_dw_stream = dc_dw_q;
  assign controller_use_z_interface_use_z                     = use_z_q;

endmodule

// File: tb/tb_nn_data_path.sv
// Self-checking bench for nn_data_path: scoreboard of expected dC/dW rows.
module tb_nn_data_path;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [47:0] w_data = '0, u_dc = '0, i_data = '0, l_data = '0;
  logic [31:0] w_l = '0, w_r = '0, u_l = '0, u_r = '0;
  logic [31:0] i_l = '0, i_r = '0, lb_l = '0, lb_r = '0, c_line = '0;
  logic        w_we = 1'b0, u_we = 1'b0, i_we = 1'b0, l_we = 1'b0, c_we = 1'b0;
  logic [11:0] c_data = '0;
  logic        code_en = 1'b0, ctrl_en = 1'b0, loc_rst = 1'b0;
  logic [47:0] dc;
  logic        use_z;

  logic [47:0] exp_q [$];
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  nn_data_path dut (
    .clk_clk                                              (clk),
    .reset_reset_n                                        (rst),
    .weight_storage_write_interface_write_data            (w_data),
    .weight_storage_write_interface_write_layer_index     (w_l),
    .weight_storage_write_interface_write_row_index       (w_r),
    .weight_storage_is_write_interface_is_write           (w_we),
    .weight_storage_update_weight_interface_dc_dw         (u_dc),
    .weight_storage_update_weight_interface_layer_index   (u_l),
    .weight_storage_update_weight_interface_row_index     (u_r),
    .weight_storage_is_update_interface_is_update         (u_we),
    .input_storage_write_interface_write_data             (i_data),
    .input_storage_write_interface_write_layer_index      (i_l),
    .input_storage_write_interface_write_row_index        (i_r),
    .input_storage_is_write_interface_is_write            (i_we),
    .label_storage_write_interface_write_data             (l_data),
    .label_storage_write_interface_write_layer_index      (lb_l),
    .label_storage_write_interface_write_row_index        (lb_r),
    .label_storage_is_write_interface_is_write            (l_we),
    .code_storage_write_interface_write_data              (c_data),
    .code_storage_write_interface_write_line              (c_line),
    .code_storage_write_interface_is_write                (c_we),
    .code_storage_enable_interface_enable                 (code_en),
    .controller_enable_interface_enable                   (ctrl_en),
    .matrix_storage_locator_reset_interface_reset         (loc_rst),
    .backpropagator_0_dc_dw_stream_interface_dc_dw_stream (dc),
    .controller_use_z_interface_use_z                     (use_z)
  );

  // Reference Q8.8 multiply
  function automatic logic [15:0] mq(input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] p;
    p = $signed(a) * $signed(b);
    return p[23:8];
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr_w(input int l, input int r, input logic [47:0] d);
    w_l = 32'(l); w_r = 32'(r); w_data = d; w_we = 1'b1; tick(1); w_we = 1'b0;
  endtask

  task automatic wr_u(input int l, input int r, input logic [47:0] d);
    u_l = 32'(l); u_r = 32'(r); u_dc = d; u_we = 1'b1; tick(1); u_we = 1'b0;
  endtask

  task automatic wr_i(input int l, input int r, input logic [47:0] d);
    i_l = 32'(l); i_r = 32'(r); i_data = d; i_we = 1'b1; tick(1); i_we = 1'b0;
  endtask

  task automatic wr_l(input int l, input int r, input logic [47:0] d);
    lb_l = 32'(l); lb_r = 32'(r); l_data = d; l_we = 1'b1; tick(1); l_we = 1'b0;
  endtask

  task automatic wr_c(input int line, input logic [11:0] d);
    c_line = 32'(line); c_data = d; c_we = 1'b1; tick(1); c_we = 1'b0;
  endtask

  task automatic load_prog(input logic [11:0] p [$]);
    foreach (p[k]) wr_c(k, p[k]);
  endtask

  // Rewind, run to HALT, then pop and compare the expected gradient row and PC
  task automatic launch_and_check(input string name, input int halt_pc);
    logic [47:0] e;
    loc_rst = 1'b1; tick(1); loc_rst = 1'b0;
    code_en = 1'b1; ctrl_en = 1'b1;
    tick(16);
    code_en = 1'b0; ctrl_en = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (dc !== e) begin
      failures++;
      $display("FAIL %s dc_dw got=%h exp=%h", name, dc, e);
    end
    checks++;
    if (dut.pc_q !== 5'(halt_pc)) begin
      failures++;
      $display("FAIL %s halt_pc got=%0d exp=%0d", name, dut.pc_q, halt_pc);
    end
  endtask

  // Reads W[l][r] out through the gradient stream (X = 1.0, label = out-of-range row)
  task automatic readback(input string name, input logic [3:0] l, input logic [3:0] r,
                          input logic [47:0] e);
    logic [11:0] p [$];
    p = '{12'h100, 12'h600, {4'h2, l, r}, 12'h701, 12'h450, 12'h500, 12'hF00};
    load_prog(p);
    exp_q.push_back(e);
    launch_and_check(name, 6);
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(2);
    checks++;
    if (dc !== 48'h0) begin failures++; $display("FAIL reset_dc got=%h exp=0", dc); end
    checks++;
    if (use_z !== 1'b0) begin failures++; $display("FAIL reset_use_z got=%b exp=0", use_z); end
    checks++;
    if (dut.pc_q !== 5'd0) begin failures++; $display("FAIL reset_pc got=%0d exp=0", dut.pc_q); end
    rst = 1'b0;
  endtask

  task automatic test_program();
    logic [11:0] p [$];
    wr_i(0, 0, 48'h0100_0100_0100);
    wr_w(0, 0, 48'h0200_0200_0200);
    wr_l(0, 0, 48'h0080_0080_0080);
    p = '{12'h100, 12'h600, 12'h200, 12'h300, 12'h400, 12'h500, 12'hF00};
    load_prog(p);
    exp_q.push_back(48'h0180_0180_0180);
    launch_and_check("program", 6);
    checks++;
    if (use_z !== 1'b0) begin failures++; $display("FAIL program_use_z got=%b exp=0", use_z); end
    code_en = 1'b1; ctrl_en = 1'b1; tick(5); code_en = 1'b0; ctrl_en = 1'b0;
    checks++;
    if (dut.pc_q !== 5'd6) begin failures++; $display("FAIL halt_hold got=%0d exp=6", dut.pc_q); end
  endtask

  task automatic test_write_update();
    wr_w(1, 2, 48'h0300_0100_FF00);
    wr_u(1, 2, 48'h0100_0100_0100);
    readback("update", 4'd1, 4'd2, 48'h0200_0000_FE00);
  endtask

  task automatic test_relu_use_z();
    logic [11:0] p [$];
    wr_w(2, 0, 48'hFF00_FF00_FF00);
    p = '{12'h100, 12'h600, 12'h220, 12'h700, 12'h300, 12'h450, 12'h500, 12'hF00};
    load_prog(p);
    exp_q.push_back(48'h0);
    launch_and_check("relu", 7);
    checks++;
    if (use_z !== 1'b0) begin failures++; $display("FAIL relu_use_z got=%b exp=0", use_z); end
    p = '{12'h100, 12'h600, 12'h220, 12'h701, 12'h450, 12'h500, 12'hF00};
    load_prog(p);
    exp_q.push_back(48'hFF00_FF00_FF00);
    launch_and_check("use_z", 6);
    checks++;
    if (use_z !== 1'b1) begin failures++; $display("FAIL setz_use_z got=%b exp=1", use_z); end
  endtask

  task automatic test_random();
    logic [11:0] p [$];
    logic [47:0] x, w, lab, g;
    logic [15:0] z, a, e;
    p = '{12'h700, 12'h101, 12'h600, 12'h232, 12'h232, 12'h300, 12'h423, 12'h500, 12'hF00};
    load_prog(p);
    for (int it = 0; it < 4; it++) begin
      x = {16'($urandom), 16'($urandom), 16'($urandom)};
      w = {16'($urandom), 16'($urandom), 16'($urandom)};
      lab = {16'($urandom), 16'($urandom), 16'($urandom)};
      wr_i(0, 1, x);
      wr_w(3, 2, w);
      wr_l(2, 3, lab);
      for (int ln = 0; ln < 3; ln++) begin
        z = mq(x[ln*16 +: 16], w[ln*16 +: 16]) + mq(x[ln*16 +: 16], w[ln*16 +: 16]);
        a = z[15] ? 16'h0 : z;
        e = a - lab[ln*16 +: 16];
        g[ln*16 +: 16] = mq(e, x[ln*16 +: 16]);
      end
      exp_q.push_back(g);
      launch_and_check($sformatf("random%0d", it), 8);
    end
  endtask

  task automatic test_gating();
    logic [11:0] p [$];
    logic [47:0] prev;
    prev = dc;
    p = '{12'h100, 12'h600, 12'h200, 12'h300, 12'h400, 12'h500, 12'hF00};
    load_prog(p);
    loc_rst = 1'b1; tick(1); loc_rst = 1'b0;
    code_en = 1'b1; ctrl_en = 1'b1; tick(3);
    ctrl_en = 1'b0; tick(5);
    checks++;
    if (dut.pc_q !== 5'd3) begin failures++; $display("FAIL ctrl_gate_pc got=%0d exp=3", dut.pc_q); end
    ctrl_en = 1'b1; code_en = 1'b0; tick(5);
    checks++;
    if (dut.pc_q !== 5'd3) begin failures++; $display("FAIL code_gate_pc got=%0d exp=3", dut.pc_q); end
    checks++;
    if (dc !== prev) begin failures++; $display("FAIL gate_dc got=%h exp=%h", dc, prev); end
    code_en = 1'b1; tick(1);
    loc_rst = 1'b1; tick(1); loc_rst = 1'b0;
    checks++;
    if (dut.pc_q !== 5'd0) begin failures++; $display("FAIL locator_pc got=%0d exp=0", dut.pc_q); end
    tick(12);
    code_en = 1'b0; ctrl_en = 1'b0;
    checks++;
    if (dc !== 48'h0180_0180_0180) begin
      failures++; $display("FAIL locator_rerun got=%h exp=018001800180", dc);
    end
  endtask

  task automatic test_reset_mid();
    loc_rst = 1'b1; tick(1); loc_rst = 1'b0;
    code_en = 1'b1; ctrl_en = 1'b1; tick(3);
    rst = 1'b1; tick(1);
    checks++;
    if (dc !== 48'h0 || use_z !== 1'b0 || dut.pc_q !== 5'd0) begin
      failures++;
      $display("FAIL mid_reset got dc=%h use_z=%b pc=%0d exp 0/0/0", dc, use_z, dut.pc_q);
    end
    rst = 1'b0; tick(12);
    code_en = 1'b0; ctrl_en = 1'b0;
    checks++;
    if (dc !== 48'h0180_0180_0180 || dut.pc_q !== 5'd6) begin
      failures++; $display("FAIL reset_rerun got dc=%h pc=%0d exp 018001800180/6", dc, dut.pc_q);
    end
  endtask

  task automatic test_boundaries();
    wr_w(1, 0, 48'h0011_0022_0033);
    wr_w(4, 0, 48'h7777_7777_7777);
    wr_w(0, 4, 48'h6666_6666_6666);
    wr_w(32'h0001_0000, 0, 48'h5555_5555_5555);
    readback("oob_w00", 4'd0, 4'd0, 48'h0200_0200_0200);
    readback("oob_w10", 4'd1, 4'd0, 48'h0011_0022_0033);
    w_l = 32'd3; w_r = 32'd1; w_data = 48'h0123_0456_0789; w_we = 1'b1;
    u_l = 32'd3; u_r = 32'd1; u_dc = 48'h0001_0001_0001; u_we = 1'b1;
    tick(1);
    w_we = 1'b0; u_we = 1'b0;
    readback("write_wins", 4'd3, 4'd1, 48'h0123_0456_0789);
  endtask

  task automatic test_pc_wrap();
    for (int k = 0; k < 32; k++) wr_c(k, 12'h000);
    wr_c(32, 12'hF00);
    loc_rst = 1'b1; tick(1); loc_rst = 1'b0;
    code_en = 1'b1; ctrl_en = 1'b1; tick(31);
    checks++;
    if (dut.pc_q !== 5'd31) begin failures++; $display("FAIL pc_31 got=%0d exp=31", dut.pc_q); end
    tick(2);
    code_en = 1'b0; ctrl_en = 1'b0;
    checks++;
    if (dut.pc_q !== 5'd1) begin failures++; $display("FAIL pc_wrap got=%0d exp=1", dut.pc_q); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(1);
    test_reset();
    test_program();
    test_write_update();
    test_relu_use_z();
    test_random();
    test_gating();
    test_reset_mid();
    test_boundaries();
    test_pc_wrap();
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
